// File: rtl/clb_splitter_fork_if.sv
// Handshake bundle for clb_splitter_fork: one wide producer side, NOUT narrow consumer lanes.
// Latency: none (wires only).
// Backpressure: in_ready toward the producer, per-lane out_ready from each consumer.
//
// Signals:
//   in_valid / in_ready / din     producer handshake, din is OWIDTH*NOUT bits, lane 0 = LSBs
//   out_valid / out_ready / dout  one valid/ready bit per lane, lane i = dout[i*OWIDTH +: OWIDTH]
// Modports: master = environment (producer + consumers), slave = the splitter itself.
interface clb_splitter_fork_if #(
    parameter int OWIDTH = 32,
    parameter int NOUT   = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OWIDTH*NOUT-1:0]   din;
    logic [NOUT-1:0]          out_valid;
    logic [NOUT-1:0]          out_ready;
    logic [NOUT*OWIDTH-1:0]   dout;

    modport master (
        output in_valid, din, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, din, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/clb_splitter_fork.sv
// Registered N-way splitter: one wide word fans out as NOUT lanes, each with its own valid/ready.
// Latency: 1 cycle din -> dout; sustains 1 word/cycle when every lane drains each cycle.
// Backpressure: in_ready low while any lane would still be pending after this cycle.
//
// Ports:
//   clk        clock, rising edge
//   r          asynchronous active-low reset
//   bus        clb_splitter_fork_if.slave (in_valid/in_ready/din, out_valid/out_ready/dout)
//   word_cnt   CNTW-bit count of fully drained words, present only with CLB_SPLITTER_FORK_CNT_EN
//
// Optional feature macro: CLB_SPLITTER_FORK_CNT_EN (adds word_cnt port and its counter).
module clb_splitter_fork #(
    parameter int OWIDTH = 32,
    parameter int NOUT   = 2,
    parameter int CNTW   = 16
) (
    input  logic                  clk,
    input  logic                  r,
    clb_splitter_fork_if.slave    bus
`ifdef CLB_SPLITTER_FORK_CNT_EN
    ,
    output logic [CNTW-1:0]       word_cnt
`endif
);
    localparam int IWIDTH = OWIDTH * NOUT;

    // Elaboration-time guard against degenerate configurations.
    if (OWIDTH < 1 || NOUT < 1 || CNTW < 1) begin : g_param_err
        $error("clb_splitter_fork: OWIDTH, NOUT and CNTW must all be >= 1");
    end

    logic [IWIDTH-1:0] data_q;
    logic [NOUT-1:0]   pend_q;   // lanes still owed the current word
    logic [NOUT-1:0]   pend_nx;  // lanes still owed after this cycle's handshakes
    logic              empty_nx;
    logic              accept;

    // out_ready on a lane that is not pending is masked by pend_q, so it is ignored.
    always_comb begin
        pend_nx  = pend_q & ~bus.out_ready;
        empty_nx = (pend_nx == '0);
        accept   = bus.in_valid & empty_nx;
    end

    // Refill is allowed in the same cycle the last lane drains, giving full throughput.
    assign bus.in_ready  = empty_nx;
    assign bus.out_valid = pend_q;
    assign bus.dout      = data_q;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            data_q <= '0;
            pend_q <= '0;
        end else if (accept) begin
            data_q <= bus.din;
            pend_q <= '1;
        end else begin
            pend_q <= pend_nx;
        end
    end

`ifdef CLB_SPLITTER_FORK_CNT_EN
    logic [CNTW-1:0] cnt_q;

    // A word counts as drained on the cycle its last pending lane completes.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cnt_q <= '0;
        end else if ((pend_q != '0) && empty_nx) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_clb_splitter_fork.sv
module tb_clb_splitter_fork;
    logic clk = 1'b0;
    logic r   = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    clb_splitter_fork_if #(.OWIDTH(32), .NOUT(2)) bus2 ();
    clb_splitter_fork_if #(.OWIDTH(8),  .NOUT(4)) bus4 ();

`ifdef CLB_SPLITTER_FORK_CNT_EN
    logic [15:0] cnt2;
    logic [3:0]  cnt4;
`endif

    clb_splitter_fork #(.OWIDTH(32), .NOUT(2), .CNTW(16)) dut2 (
        .clk (clk),
        .r   (r),
        .bus (bus2)
`ifdef CLB_SPLITTER_FORK_CNT_EN
        ,
        .word_cnt (cnt2)
`endif
    );

    clb_splitter_fork #(.OWIDTH(8), .NOUT(4), .CNTW(4)) dut4 (
        .clk (clk),
        .r   (r),
        .bus (bus4)
`ifdef CLB_SPLITTER_FORK_CNT_EN
        ,
        .word_cnt (cnt4)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        bus2.din = 64'h1234_5678_9ABC_DEF0; bus2.in_valid = 1'b1; bus2.out_ready = 2'b00;
        bus4.din = 32'hCAFE_F00D;           bus4.in_valid = 1'b1; bus4.out_ready = 4'b0000;
        @(posedge clk); #2;
        bus2.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        n_chk++;
        if (bus2.out_valid !== 2'b11) begin
            n_fail++; $display("FAIL reset_preload out_valid=%b exp=11", bus2.out_valid);
        end
        #1 r = 1'b0;
        #1;
        n_chk++;
        if (bus2.out_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_out_valid got=%b exp=00", bus2.out_valid);
        end
        n_chk++;
        if (bus2.dout !== 64'h0) begin
            n_fail++; $display("FAIL reset_dout got=%h exp=0", bus2.dout);
        end
        n_chk++;
        if (bus2.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus2.in_ready);
        end
        n_chk++;
        if (bus4.out_valid !== 4'b0000 || bus4.dout !== 32'h0) begin
            n_fail++; $display("FAIL reset_dut4 out_valid=%b dout=%h exp=0/0", bus4.out_valid, bus4.dout);
        end
`ifdef CLB_SPLITTER_FORK_CNT_EN
        n_chk++;
        if (cnt2 !== 16'd0 || cnt4 !== 4'd0) begin
            n_fail++; $display("FAIL reset_word_cnt got=%0d/%0d exp=0/0", cnt2, cnt4);
        end
`endif
        @(negedge clk);
        r = 1'b1;
    endtask

    task automatic test_split();
        @(negedge clk);
        bus2.din = 64'hD0D0D0D0_F0F0F0F0; bus2.in_valid = 1'b1; bus2.out_ready = 2'b11;
        #1;
        n_chk++;
        if (bus2.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL split_in_ready got=%b exp=1", bus2.in_ready);
        end
        @(posedge clk); #1;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 2'b00;
        n_chk++;
        if (bus2.out_valid !== 2'b11) begin
            n_fail++; $display("FAIL split_out_valid got=%b exp=11", bus2.out_valid);
        end
        n_chk++;
        if (bus2.dout[31:0] !== 32'hF0F0F0F0) begin
            n_fail++; $display("FAIL split_lane0 got=%h exp=f0f0f0f0", bus2.dout[31:0]);
        end
        n_chk++;
        if (bus2.dout[63:32] !== 32'hD0D0D0D0) begin
            n_fail++; $display("FAIL split_lane1 got=%h exp=d0d0d0d0", bus2.dout[63:32]);
        end
    endtask

    task automatic test_skew();
        // lane0 drains first while a new word waits; it must not be taken
        @(negedge clk);
        bus2.out_ready = 2'b01;
        bus2.in_valid  = 1'b1;
        bus2.din       = 64'h11111111_22222222;
        #1;
        n_chk++;
        if (bus2.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL skew_in_ready_a got=%b exp=0", bus2.in_ready);
        end
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        n_chk++;
        if (bus2.out_valid !== 2'b10) begin
            n_fail++; $display("FAIL skew_out_valid_a got=%b exp=10", bus2.out_valid);
        end
        n_chk++;
        if (bus2.dout[63:32] !== 32'hD0D0D0D0) begin
            n_fail++; $display("FAIL skew_lane1_hold got=%h exp=d0d0d0d0", bus2.dout[63:32]);
        end
        // ready on the already-drained lane0 must be ignored
        @(negedge clk);
        bus2.out_ready = 2'b11;
        #1;
        n_chk++;
        if (bus2.in_ready !== 1'b1 || bus2.out_valid !== 2'b10) begin
            n_fail++; $display("FAIL skew_in_ready_b in_ready=%b out_valid=%b exp=1/10", bus2.in_ready, bus2.out_valid);
        end
        @(posedge clk); #1;
        n_chk++;
        if (bus2.out_valid !== 2'b00 || bus2.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL skew_empty out_valid=%b in_ready=%b exp=00/1", bus2.out_valid, bus2.in_ready);
        end
`ifdef CLB_SPLITTER_FORK_CNT_EN
        n_chk++;
        if (cnt2 !== 16'd1) begin
            n_fail++; $display("FAIL skew_word_cnt got=%0d exp=1", cnt2);
        end
`endif
        bus2.out_ready = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [63:0] w;
        for (int k = 0; k < 8; k++) begin
            w = {32'hA000_0000 + 32'(k), 32'h0B00_0000 + 32'(k)};
            @(negedge clk);
            bus2.din = w; bus2.in_valid = 1'b1; bus2.out_ready = 2'b11;
            #1;
            n_chk++;
            if (bus2.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_in_ready word=%0d got=%b exp=1", k, bus2.in_ready);
            end
            @(posedge clk); #1;
            n_chk++;
            if (bus2.out_valid !== 2'b11 || bus2.dout !== w) begin
                n_fail++; $display("FAIL b2b_word word=%0d got=%b/%h exp=11/%h", k, bus2.out_valid, bus2.dout, w);
            end
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (bus2.out_valid !== 2'b00) begin
            n_fail++; $display("FAIL b2b_drained got=%b exp=00", bus2.out_valid);
        end
`ifdef CLB_SPLITTER_FORK_CNT_EN
        n_chk++;
        if (cnt2 !== 16'd9) begin
            n_fail++; $display("FAIL b2b_word_cnt got=%0d exp=9", cnt2);
        end
`endif
        bus2.out_ready = 2'b00;
    endtask

    task automatic test_random_stall();
        logic [31:0] words [1000];
        int          wr;
        int          rd [4];
        int          cyc;
        logic [3:0]  orr;
        logic [3:0]  pend;
        logic        exp_rdy;
        logic        done;
        wr   = 0;
        cyc  = 0;
        rd   = '{default: 0};
        done = 1'b0;
        foreach (words[i]) words[i] = $urandom;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            orr = 4'($urandom);
            bus4.out_ready = orr;
            bus4.in_valid  = (wr < 1000) && ($urandom_range(0, 3) != 0);
            bus4.din       = (wr < 1000) ? words[wr] : 32'h0;
            #1;
            for (int i = 0; i < 4; i++) pend[i] = (rd[i] < wr);
            exp_rdy = ((pend & ~orr) == 4'b0000);
            n_chk++;
            if (bus4.out_valid !== pend) begin
                n_fail++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, bus4.out_valid, pend);
            end
            n_chk++;
            if (bus4.in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, bus4.in_ready, exp_rdy);
            end
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && orr[i]) begin
                    n_chk++;
                    if (bus4.dout[i*8 +: 8] !== words[rd[i]][i*8 +: 8]) begin
                        n_fail++; $display("FAIL rand_lane%0d word=%0d got=%h exp=%h", i, rd[i], bus4.dout[i*8 +: 8], words[rd[i]][i*8 +: 8]);
                    end
                    rd[i]++;
                end
            end
            if (bus4.in_valid && exp_rdy) wr++;
            cyc++;
            done = (wr == 1000) && (rd[0] == 1000) && (rd[1] == 1000) && (rd[2] == 1000) && (rd[3] == 1000);
        end
        @(negedge clk);
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 4'b0000;
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL rand_timeout words_in=%0d lanes=%0d/%0d/%0d/%0d exp=1000", wr, rd[0], rd[1], rd[2], rd[3]);
        end
        #1;
        n_chk++;
        if (bus4.out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL rand_final_out_valid got=%b exp=0000", bus4.out_valid);
        end
`ifdef CLB_SPLITTER_FORK_CNT_EN
        n_chk++;
        if (cnt4 !== 4'd8) begin
            n_fail++; $display("FAIL rand_word_cnt got=%0d exp=8", cnt4);
        end
`endif
    endtask

`ifdef CLB_SPLITTER_FORK_CNT_EN
    task automatic test_wrap();
        @(negedge clk);
        r = 1'b0;
        @(negedge clk);
        r = 1'b1;
        #1;
        n_chk++;
        if (cnt4 !== 4'd0) begin
            n_fail++; $display("FAIL wrap_start got=%0d exp=0", cnt4);
        end
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            bus4.din = 32'(k * 3 + 1); bus4.in_valid = 1'b1; bus4.out_ready = 4'b1111;
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        bus4.out_ready = 4'b0000;
        #1;
        n_chk++;
        if (cnt4 !== 4'd1) begin
            n_fail++; $display("FAIL wrap_word_cnt got=%0d exp=1", cnt4);
        end
    endtask
`endif

    initial begin
        bus2.in_valid = 1'b0; bus2.din = '0; bus2.out_ready = '0;
        bus4.in_valid = 1'b0; bus4.din = '0; bus4.out_ready = '0;
        repeat (2) @(negedge clk);
        r = 1'b1;
        test_reset();
        test_split();
        test_skew();
        test_back_to_back();
        test_random_stall();
`ifdef CLB_SPLITTER_FORK_CNT_EN
        test_wrap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
